decode_ctrl_stage: RTL
======================

Name: decode_ctrl_stage

Overview:
- Registered, parametrised instruction-decode/control stage for the pipelined RV64I core.
- Decodes RV64I plus optional RV64M into a control bundle and holds it in an ID/EX output register with a valid/ready handshake.
- Detects load-use hazards and inserts bubbles.
- Sequences multi-cycle divide ops through a small FSM; branch/jump resolution stays in EX.

Parameters:
XLEN, 64, datapath width; only 32 or 64 legal; 32 makes all *W opcodes illegal
EN_M, 1, 1 decodes MUL/DIV/REM (+W variants); 0 makes them illegal
ALU_SEL_W, 6, width of alu_sel_o

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instr_i  in  32  instruction from IF
if_valid_i  in  1  instr_i valid
if_ready_o  out  1  stage accepts instr_i this cycle
id_valid_o  out  1  output bundle valid
id_ready_i  in  1  EX accepts bundle
flush_i  in  1  kill held and incoming instruction (taken branch/jump in EX)
ex_valid_i / ex_dmem_rd_i / ex_rd_i  in  1/1/5  instruction currently in EX: valid, is load, destination
md_done_i  in  1  divider finished
md_kill_o  out  1  one-cycle abort pulse to divider
alu_sel_o  out  ALU_SEL_W  ALU op
alu_src_a_o, alu_src_b_o, dmem_wr_o, dmem_rd_o, reg_wr_o, branch_o, jump_o, jalr_o, word_o, muldiv_o, illegal_o  out  1 each
result_src_o  out  2  0 ALU, 1 memory, 2 PC+4
imm_src_o  out  3  0 I, 1 S, 2 B, 3 J, 4 U-LUI, 5 U-AUIPC
rd_o, rs1_o, rs2_o  out  5 each  register indices

Behaviour:
- Reset: every output 0, FSM = IDLE.
- alu_sel encoding:
  - ADD0 SUB1 AND2 OR3 XOR4 SLL5 SRL6 SRA7 SLT8 SLTU9.
  - Branch: BEQ16 BNE17 BLT18 BGE19 BLTU20 BGEU21.
  - M ops: 32+funct3.
  - Word ops use the base code with word_o=1.
- Decode rules:
  - LOAD/STORE/LUI/AUIPC/JAL/JALR use ADD.
  - jalr_o=1 only for opcode 1100111; jump_o=1 for JAL and JALR.
  - Unknown opcode/funct3/funct7 combinations → illegal_o=1, and reg_wr_o, dmem_wr_o, dmem_rd_o, branch_o, jump_o all 0.
  - SLLI/SRLI/SRAI use a 6-bit shamt when XLEN=64: funct7[6:1] is checked, funct7[0] is ignored.
  - rs1_o/rs2_o are forced 0 for formats without those fields (U, J; rs2 for I-type).
- Load-use hazard (hz) = ex_valid_i & ex_dmem_rd_i & ex_rd_i≠0 & (ex_rd_i==rs1 or ex_rd_i==rs2 of instr_i), using the forced indices.
- adv = ~id_valid_o | id_ready_i.
- if_ready_o = adv & ~hz & ~flush_i & (state==IDLE). Combinational; no path from instr_i to if_ready_o except via hz.
- Register load, on the rising edge:
  - flush_i: id_valid_o←0, and the incoming instr is not consumed. Highest priority after rst.
  - adv & if_valid_i & if_ready_o: bundle←decode(instr_i), id_valid_o←1.
  - adv & (hz or ~if_valid_i or state≠IDLE): id_valid_o←0 (bubble); bundle fields may hold.
  - ~adv: all outputs hold.
- FSM, states IDLE and WAIT_MD:
  - IDLE→WAIT_MD when a DIV/DIVU/REM/REMU (incl. W) is accepted.
  - WAIT_MD→IDLE on md_done_i.
  - flush_i in WAIT_MD → IDLE and md_kill_o=1 for exactly that cycle.
  - If md_done_i and flush_i coincide: go to IDLE, no md_kill_o.
- MUL ops are single-issue, with no FSM wait.
- Latency: accepted instruction appears on id_valid_o the next cycle. Sustained throughput is 1/cycle absent hazards.

Test Plan:
- After rst: all outputs 0.
- addi x1,x0,5 (0x00500093) with id_ready_i=1 → next cycle id_valid_o=1, alu_sel=0, alu_src_b=1, reg_wr=1, rd=1, imm_src=0.
- ld x2,0(x1) in EX (ex_valid=1, ex_dmem_rd=1, ex_rd=2) with add x3,x2,x1 presented → if_ready_o=0 one cycle and a bubble; next cycle ex_dmem_rd=0 → accepted, alu_sel=0, rs1=2, rs2=1.
- Same hazard case but ex_rd_i=0 → no stall.
- div x5,x6,x7 (0x027342B3) with EN_M=1 → muldiv=1, alu_sel=36, FSM WAIT_MD, if_ready_o=0 until md_done_i; with EN_M=0 → illegal_o=1, reg_wr=0.
- flush_i during WAIT_MD → md_kill_o one-cycle pulse, id_valid_o=0, if_ready_o=1 the following cycle.
- id_ready_i=0 for 3 cycles with beq held → outputs stable, alu_sel=16, branch_o=1; then divw (0x0273C2BB) → word_o=1, alu_sel=36; opcode 0x7F → illegal_o=1.

Source files
------------

// File: rtl/decode_ctrl_stage_if.sv
// Purpose : bundles the IF-side handshake, the EX-side hazard/flush/divider signals and the
//           ID/EX control bundle of decode_ctrl_stage into one port.
// Ports   : master = surrounding pipeline (drives instr/handshake/EX status),
//           slave  = decode stage (drives if_ready, md_kill and the registered control bundle).
interface decode_ctrl_stage_if #(
    parameter int ALU_SEL_W = 6
);
    logic [31:0]          instr_i;
    logic                 if_valid_i;
    logic                 if_ready_o;
    logic                 id_valid_o;
    logic                 id_ready_i;
    logic                 flush_i;
    logic                 ex_valid_i;
    logic                 ex_dmem_rd_i;
    logic [4:0]           ex_rd_i;
    logic                 md_done_i;
    logic                 md_kill_o;
    logic [ALU_SEL_W-1:0] alu_sel_o;
    logic                 alu_src_a_o;
    logic                 alu_src_b_o;
    logic                 dmem_wr_o;
    logic                 dmem_rd_o;
    logic                 reg_wr_o;
    logic                 branch_o;
    logic                 jump_o;
    logic                 jalr_o;
    logic                 word_o;
    logic                 muldiv_o;
    logic                 illegal_o;
    logic [1:0]           result_src_o;
    logic [2:0]           imm_src_o;
    logic [4:0]           rd_o;
    logic [4:0]           rs1_o;
    logic [4:0]           rs2_o;

    modport master (
        output instr_i, if_valid_i, id_ready_i, flush_i, ex_valid_i, ex_dmem_rd_i, ex_rd_i, md_done_i,
        input  if_ready_o, id_valid_o, md_kill_o, alu_sel_o, alu_src_a_o, alu_src_b_o, dmem_wr_o,
               dmem_rd_o, reg_wr_o, branch_o, jump_o, jalr_o, word_o, muldiv_o, illegal_o,
               result_src_o, imm_src_o, rd_o, rs1_o, rs2_o
    );

    modport slave (
        input  instr_i, if_valid_i, id_ready_i, flush_i, ex_valid_i, ex_dmem_rd_i, ex_rd_i, md_done_i,
        output if_ready_o, id_valid_o, md_kill_o, alu_sel_o, alu_src_a_o, alu_src_b_o, dmem_wr_o,
               dmem_rd_o, reg_wr_o, branch_o, jump_o, jalr_o, word_o, muldiv_o, illegal_o,
               result_src_o, imm_src_o, rd_o, rs1_o, rs2_o
    );
endinterface

// File: rtl/decode_ctrl_stage.sv
// Purpose : RV64I(+M) decode into a control bundle held in the ID/EX register, with load-use stall and divide wait.
// Latency : one cycle from instr acceptance to id_valid_o; 1 instr/cycle sustained without hazards.
// Backpr. : if_ready_o drops on id_ready_i low with a held bundle, load-use hazard, flush_i, or divide outstanding.
// Ports   : clk, rst (sync, active high); bus = decode_ctrl_stage_if.slave (IF handshake, EX status, bundle).
module decode_ctrl_stage #(
    parameter int XLEN      = 64,
    parameter int EN_M      = 1,
    parameter int ALU_SEL_W = 6
) (
    input logic                clk,
    input logic                rst,
    decode_ctrl_stage_if.slave bus
);
    localparam bit RV64 = (XLEN == 64);

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OP_REG = 7'b0110011, OP_REG32 = 7'b0111011;

    localparam logic [ALU_SEL_W-1:0] ALU_ADD = ALU_SEL_W'(0), ALU_SUB = ALU_SEL_W'(1);
    localparam logic [ALU_SEL_W-1:0] ALU_AND = ALU_SEL_W'(2), ALU_OR = ALU_SEL_W'(3);
    localparam logic [ALU_SEL_W-1:0] ALU_XOR = ALU_SEL_W'(4), ALU_SLL = ALU_SEL_W'(5);
    localparam logic [ALU_SEL_W-1:0] ALU_SRL = ALU_SEL_W'(6), ALU_SRA = ALU_SEL_W'(7);
    localparam logic [ALU_SEL_W-1:0] ALU_SLT = ALU_SEL_W'(8), ALU_SLTU = ALU_SEL_W'(9);
    localparam logic [ALU_SEL_W-1:0] ALU_BR = ALU_SEL_W'(16), ALU_M = ALU_SEL_W'(32);

    typedef struct packed {
        logic [ALU_SEL_W-1:0] alu_sel;
        logic                 alu_src_a;
        logic                 alu_src_b;
        logic                 dmem_wr;
        logic                 dmem_rd;
        logic                 reg_wr;
        logic                 branch;
        logic                 jump;
        logic                 jalr;
        logic                 word;
        logic                 muldiv;
        logic                 illegal;
        logic [1:0]           result_src;
        logic [2:0]           imm_src;
        logic [4:0]           rd;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
    } ctrl_t;

    typedef enum logic {IDLE, WAIT_MD} state_t;

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    ctrl_t      dec, ctrl_q;
    logic       ill, is_div, sh_zero, sh_alt;
    logic       hz, adv, if_ready, accept, id_valid, md_kill;
    state_t     state, state_nxt;

    assign opcode = bus.instr_i[6:0];
    assign f3     = bus.instr_i[14:12];
    assign f7     = bus.instr_i[31:25];

    // RV64 immediate shifts carry shamt[5] in funct7[0], so only funct7[6:1] selects the op.
    assign sh_zero = RV64 ? (f7[6:1] == 6'b000000) : (f7 == 7'b0000000);
    assign sh_alt  = RV64 ? (f7[6:1] == 6'b010000) : (f7 == 7'b0100000);

    always_comb begin
        dec     = '0;
        ill     = 1'b0;
        is_div  = 1'b0;
        dec.rd  = bus.instr_i[11:7];
        dec.rs1 = bus.instr_i[19:15];
        dec.rs2 = bus.instr_i[24:20];
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                dec.reg_wr    = 1'b1;
                dec.alu_src_a = (opcode == OP_AUIPC);
                dec.alu_src_b = 1'b1;
                dec.imm_src   = (opcode == OP_AUIPC) ? 3'd5 : 3'd4;
                dec.rs1       = '0;
                dec.rs2       = '0;
            end
            OP_JAL: begin
                {dec.reg_wr, dec.jump, dec.alu_src_a, dec.alu_src_b} = 4'b1111;
                dec.result_src = 2'd2;
                dec.imm_src    = 3'd3;
                dec.rs1        = '0;
                dec.rs2        = '0;
            end
            OP_JALR: begin
                {dec.reg_wr, dec.jump, dec.jalr, dec.alu_src_b} = 4'b1111;
                dec.result_src = 2'd2;
                dec.rs2        = '0;
                ill            = (f3 != 3'b000);
            end
            OP_BRANCH: begin
                dec.branch  = 1'b1;
                dec.imm_src = 3'd2;
                dec.rd      = '0;
                case (f3)
                    3'b000:  dec.alu_sel = ALU_BR;
                    3'b001:  dec.alu_sel = ALU_BR | ALU_SEL_W'(1);
                    3'b100:  dec.alu_sel = ALU_BR | ALU_SEL_W'(2);
                    3'b101:  dec.alu_sel = ALU_BR | ALU_SEL_W'(3);
                    3'b110:  dec.alu_sel = ALU_BR | ALU_SEL_W'(4);
                    3'b111:  dec.alu_sel = ALU_BR | ALU_SEL_W'(5);
                    default: ill = 1'b1;
                endcase
            end
            OP_LOAD: begin
                {dec.dmem_rd, dec.reg_wr, dec.alu_src_b} = 3'b111;
                dec.result_src = 2'd1;
                dec.rs2        = '0;
                // LD and LWU exist only on RV64
                ill = (f3 == 3'b111) || (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
            end
            OP_STORE: begin
                {dec.dmem_wr, dec.alu_src_b} = 2'b11;
                dec.imm_src = 3'd1;
                dec.rd      = '0;
                ill         = f3[2] || (!RV64 && f3 == 3'b011);
            end
            OP_IMM: begin
                {dec.reg_wr, dec.alu_src_b} = 2'b11;
                dec.rs2 = '0;
                case (f3)
                    3'b000: dec.alu_sel = ALU_ADD;
                    3'b010: dec.alu_sel = ALU_SLT;
                    3'b011: dec.alu_sel = ALU_SLTU;
                    3'b100: dec.alu_sel = ALU_XOR;
                    3'b110: dec.alu_sel = ALU_OR;
                    3'b111: dec.alu_sel = ALU_AND;
                    3'b001: begin dec.alu_sel = ALU_SLL; ill = !sh_zero; end
                    default: begin dec.alu_sel = sh_alt ? ALU_SRA : ALU_SRL; ill = !(sh_zero || sh_alt); end
                endcase
            end
            OP_IMM32: begin
                {dec.reg_wr, dec.alu_src_b, dec.word} = 3'b111;
                dec.rs2 = '0;
                ill     = !RV64;
                case (f3)
                    3'b000:  dec.alu_sel = ALU_ADD;
                    3'b001:  begin dec.alu_sel = ALU_SLL; if (f7 != 7'b0000000) ill = 1'b1; end
                    3'b101: begin
                        dec.alu_sel = f7[5] ? ALU_SRA : ALU_SRL;
                        if (f7 != 7'b0000000 && f7 != 7'b0100000) ill = 1'b1;
                    end
                    default: ill = 1'b1;
                endcase
            end
            OP_REG, OP_REG32: begin
                dec.reg_wr = 1'b1;
                dec.word   = (opcode == OP_REG32);
                if (dec.word && !RV64) ill = 1'b1;
                case (f7)
                    7'b0000000: begin
                        case (f3)
                            3'b000: dec.alu_sel = ALU_ADD;
                            3'b001: dec.alu_sel = ALU_SLL;
                            3'b010: dec.alu_sel = ALU_SLT;
                            3'b011: dec.alu_sel = ALU_SLTU;
                            3'b100: dec.alu_sel = ALU_XOR;
                            3'b101: dec.alu_sel = ALU_SRL;
                            3'b110: dec.alu_sel = ALU_OR;
                            default: dec.alu_sel = ALU_AND;
                        endcase
                        // word forms only define ADDW/SLLW/SRLW
                        if (dec.word && !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) ill = 1'b1;
                    end
                    7'b0100000: begin
                        dec.alu_sel = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
                        if (f3 != 3'b000 && f3 != 3'b101) ill = 1'b1;
                    end
                    7'b0000001: begin
                        dec.muldiv  = 1'b1;
                        dec.alu_sel = ALU_M | ALU_SEL_W'(f3);
                        is_div      = f3[2];
                        if (EN_M == 0) ill = 1'b1;
                        // MULHx have no word form
                        if (dec.word && (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011)) ill = 1'b1;
                    end
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        // An illegal instruction carries no side effects and no register indices, so it never stalls.
        if (ill) begin
            dec         = '0;
            dec.illegal = 1'b1;
            is_div      = 1'b0;
        end
    end

    assign hz = bus.ex_valid_i && bus.ex_dmem_rd_i && (bus.ex_rd_i != 5'd0)
                && ((bus.ex_rd_i == dec.rs1) || (bus.ex_rd_i == dec.rs2));

    assign adv      = !id_valid || bus.id_ready_i;
    assign if_ready = !rst && adv && !hz && !bus.flush_i && (state == IDLE);
    assign accept   = bus.if_valid_i && if_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            ctrl_q   <= '0;
        end else if (bus.flush_i) begin
            id_valid <= 1'b0;
        end else if (adv) begin
            if (accept) begin
                ctrl_q   <= dec;
                id_valid <= 1'b1;
            end else begin
                id_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        md_kill   = 1'b0;
        case (state)
            IDLE: if (accept && is_div) state_nxt = WAIT_MD;
            WAIT_MD: begin
                // a finishing divider needs no abort even if EX flushes in the same cycle
                if (bus.md_done_i) begin
                    state_nxt = IDLE;
                end else if (bus.flush_i) begin
                    state_nxt = IDLE;
                    md_kill   = !rst;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.if_ready_o   = if_ready;
    assign bus.id_valid_o   = id_valid;
    assign bus.md_kill_o    = md_kill;
    assign bus.alu_sel_o    = ctrl_q.alu_sel;
    assign bus.alu_src_a_o  = ctrl_q.alu_src_a;
    assign bus.alu_src_b_o  = ctrl_q.alu_src_b;
    assign bus.dmem_wr_o    = ctrl_q.dmem_wr;
    assign bus.dmem_rd_o    = ctrl_q.dmem_rd;
    assign bus.reg_wr_o     = ctrl_q.reg_wr;
    assign bus.branch_o     = ctrl_q.branch;
    assign bus.jump_o       = ctrl_q.jump;
    assign bus.jalr_o       = ctrl_q.jalr;
    assign bus.word_o       = ctrl_q.word;
    assign bus.muldiv_o     = ctrl_q.muldiv;
    assign bus.illegal_o    = ctrl_q.illegal;
    assign bus.result_src_o = ctrl_q.result_src;
    assign bus.imm_src_o    = ctrl_q.imm_src;
    assign bus.rd_o         = ctrl_q.rd;
    assign bus.rs1_o        = ctrl_q.rs1;
    assign bus.rs2_o        = ctrl_q.rs2;
endmodule
